sar_search: RTL

- Successive-approximation controller. Finds an unknown N-bit target value using only eq/lt/gt verdicts from an external magnitude comparator.
- Drives a trial word to the comparator. Reads back trial-vs-target relation each cycle and resolves one bit per cycle, MSB first.
- Sits beside the team's N-bit magnitude comparator and closes the loop around it (ADC-style SAR, threshold search).

---
 rtl/sar_search_pkg.sv | 13 +
 rtl/sar_search_verdict.sv | 24 ++
 rtl/sar_search.sv | 117 +++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared state encoding for the successive-approximation search controller.
// No logic; imported by sar_search and sar_search_verdict.
package sar_search_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sar_search_verdict.sv
// Decodes an eq/lt/gt comparator verdict into keep/hit/invalid flags.
// Latency: combinational. Backpressure: none.
// Anything other than exactly one verdict line high is invalid and resolves as "clear the bit".
module sar_search_verdict
    import sar_search_pkg::*;
(
    input  logic cmp_eq,
    input  logic cmp_lt,
    input  logic cmp_gt,
    output logic keep_bit,
    output logic hit_eq,
    output logic invalid
);

    logic one_hot;

    always_comb begin
        one_hot  = (cmp_eq ^ cmp_lt ^ cmp_gt) & ~(cmp_eq & cmp_lt & cmp_gt);
        invalid  = ~one_hot;
        keep_bit = one_hot & (cmp_eq | cmp_lt);
        hit_eq   = one_hot & cmp_eq;
    end

endmodule

// File: rtl/sar_search.sv
// SAR controller: resolves an N-bit target MSB-first from external comparator verdicts.
// Latency: done pulses N+1 cycles after start (k+1 with SAR_EARLY_EXIT_EN and an eq hit on trial k).
// Backpressure: start is accepted only in IDLE; pulses while busy are dropped, not queued.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    input  logic         cmp_gt,
    output logic [N-1:0] trial,
    output logic         trial_valid,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t        state;
    logic [N-1:0]  acc;
    logic [IW-1:0] idx;

    logic          keep_bit;
    logic          hit_eq;
    logic          invalid;
    logic [N-1:0]  bit_mask;
    logic [N-1:0]  acc_next;
    logic          finish;

    sar_search_verdict u_verdict (
        .cmp_eq   (cmp_eq),
        .cmp_lt   (cmp_lt),
        .cmp_gt   (cmp_gt),
        .keep_bit (keep_bit),
        .hit_eq   (hit_eq),
        .invalid  (invalid)
    );

    // An eq hit keeps the bit, so acc_next already equals the current trial on early exit.
    always_comb begin
        bit_mask      = '0;
        bit_mask[idx] = 1'b1;
        acc_next      = keep_bit ? (acc | bit_mask) : acc;
        finish        = (idx == '0) || (EARLY_EXIT && hit_eq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            idx         <= '0;
            trial       <= '0;
            trial_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= 1'b0;
                    trial <= '0;
                    if (start) begin
                        acc         <= '0;
                        idx         <= IW'(N - 1);
                        trial       <= {1'b1, {(N-1){1'b0}}};
                        trial_valid <= 1'b1;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        state       <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc <= acc_next;
                    if (invalid) begin
                        err <= 1'b1;
                    end
                    if (finish) begin
                        result      <= acc_next;
                        trial       <= '0;
                        trial_valid <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        trial <= acc_next | (bit_mask >> 1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    trial       <= '0;
                    trial_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
